note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Sequences the 8-bit tone-divider counter: steps through a programmable pattern of
//  {duration, divider} entries and drives the counter's count_to and reset inputs.
//  Each note is held for a programmed number of tick strobes.
//  Rests are muted, and the pattern plays once or loops.
//  Sits between the control front end (pattern writes, start/stop) and the tone counter.
// PARAMETERS
//  DEPTH   16  pattern entries (power of two); ADDR_W = clog2(DEPTH)
//  DUR_W   8   duration field width, in tick units
// PORTS
//  clk       in   1            system clock; all logic on posedge
//  reset     in   1            synchronous, active-high; clears all state and outputs
//  tick      in   1            one-cycle duration time-base strobe
//  start     in   1            begin playback at entry 0 (sampled only in IDLE)
//  stop      in   1            abort playback, any state
//  loop_en   in   1            1: wrap to entry 0 at end of pattern; 0: finish
//  wr_en     in   1            pattern write strobe
//  wr_addr   in   ADDR_W       pattern write address
//  wr_data   in   DUR_W+8      {dur[DUR_W-1:0], div[7:0]}
//  count_to  out  8            divider value to tone counter
//  div_reset out  1            one-cycle reset pulse to tone counter at each note load
//  mute      out  1            1 = suppress audio (idle or rest note)
//  busy      out  1            1 while not IDLE
//  step      out  ADDR_W       address of entry being fetched/played
//  done      out  1            one-cycle pulse on natural end of pattern (not on stop)
// BEHAVIOUR
//  - Reset values: count_to=0, div_reset=0, mute=1, busy=0, step=0, done=0, state IDLE.
//    Pattern RAM is not reset.
//  - States: IDLE, FETCH, LOAD, PLAY, FINISH. All outputs are registered.
//  - IDLE: on start & !stop -> step=0, FETCH. Otherwise hold.
//  - FETCH: RAM read of step is issued (registered read) -> LOAD next cycle.
//  - LOAD, entry dur==0 (end marker):
//      loop_en & step!=0 -> step=0, FETCH.
//      otherwise -> FINISH. An empty pattern (marker at entry 0) never loops.
//  - LOAD, entry dur!=0:
//      count_to<=div, remain<=dur, div_reset<=1 for exactly one cycle,
//      mute<=(div==0), then PLAY.
//      Latency: start sampled at edge E0 -> count_to/div_reset valid after E2.
//  - PLAY: each tick decrements remain. A tick with remain==1 ends the note:
//      step!=DEPTH-1 -> step+1, FETCH.
//      step==DEPTH-1 -> step=0, FETCH if loop_en, else FINISH.
//      A note lasts exactly dur ticks.
//  - Ticks arriving in FETCH/LOAD are dropped (2-cycle gap is negligible vs tick period).
//  - FINISH: done=1 for one cycle, mute=1, count_to=0 -> IDLE.
//  - stop in any non-IDLE state (including the cycle a note ends) -> IDLE next cycle:
//      mute=1, count_to=0, no done pulse.
//    start & stop together in IDLE: stop wins.
//  - start while busy: ignored.
//  - loop_en is sampled at each end-of-pattern decision, not latched at start.
//  - Writes are accepted in any state. RAM is read-first: a write to the address being
//    read in the same cycle returns old data. Edits take effect at the entry's next fetch.
//  - div==0 rest: count_to=0 is driven (counter free-runs), mute=1 for the note duration.
//  - Arithmetic: remain is DUR_W bits and never underflows (advance at 1, not 0).
//    step wraps modulo DEPTH.
// STRUCTURE
//  - seq_defs.vh (shared include): state encodings; field positions DIV_LSB=0, DIV_W=8,
//    DUR_LSB=8; END_MARK_DUR=0.
//  - Sub-module seq_pattern_ram: DEPTH x (DUR_W+8), sync write, registered read-first.
//  - Top: FSM, step/remain counters, output registers.
// TESTING
//  1. Reset: hold reset 3 cycles with start=1 -> mute=1, busy=0, count_to=0, div_reset=0.
//  2. Entries {3,0x40},{2,0x20},{0,x}; loop_en=0; start ->
//       count_to=0x40 two edges after start with one-cycle div_reset;
//       0x40 held 3 ticks, then 0x20 held 2 ticks;
//       done pulses once; busy=0, mute=1.
//  3. Same pattern, loop_en=1 -> sequence 0x40,0x20,0x40,... with no done;
//       clear loop_en mid-note -> finishes at next end marker with done.
//  4. Rest entry {4,0x00} -> mute=1 and count_to=0 for 4 ticks, then next note unmuted.
//  5. stop during PLAY at remain=2 -> IDLE next cycle, no done;
//       start+stop together in IDLE -> stays IDLE;
//       start while busy -> no effect on step.
//  6. All DEPTH entries dur=1 with no marker, loop_en=0 -> step 0..15, then done.
//       Also: write entry 0 = {0,x} -> start gives done 3 cycles after start with no note.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: geometry, pattern entry layout, FSM states.
// A pattern entry is {dur, div}; dur == END_MARK_DUR marks the end of the pattern.
package note_sequencer_pkg;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = $clog2(DEPTH);
  localparam int DUR_W        = 8;
  localparam int DIV_W        = 8;
  localparam int END_MARK_DUR = 0;

  typedef struct packed {
    logic [DUR_W-1:0] dur;
    logic [DIV_W-1:0] div;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the front end (master) and the note sequencer (slave).
// Carries pattern writes, playback control, tick strobe and tone-counter drive.
interface note_sequencer_if;
  import note_sequencer_pkg::*;

  logic              tick;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  entry_t            wr_data;
  logic [DIV_W-1:0]  count_to;
  logic              div_reset;
  logic              mute;
  logic              busy;
  logic [ADDR_W-1:0] step;
  logic              done;

  modport master (
    output tick, start, stop, loop_en, wr_en, wr_addr, wr_data,
    input  count_to, div_reset, mute, busy, step, done
  );

  modport slave (
    input  tick, start, stop, loop_en, wr_en, wr_addr, wr_data,
    output count_to, div_reset, mute, busy, step, done
  );

endinterface

// File: rtl/note_sequencer_pattern_ram.sv
// Pattern store: DEPTH entries, synchronous write, registered read-first (1-cycle read).
// No backpressure: a write and a read may hit the same address; the read returns old data.
module note_sequencer_pattern_ram
  import note_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output entry_t            rd_data
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps through {dur, div} pattern entries and drives the tone counter; all outputs registered.
// Latency: start at edge E0 -> count_to/div_reset valid after E2; no backpressure, ticks in FETCH/LOAD dropped.
module note_sequencer
  import note_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  note_sequencer_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [DUR_W-1:0]  remain_q, remain_d;
  logic [DIV_W-1:0]  count_to_q, count_to_d;
  logic              div_reset_q, div_reset_d;
  logic              mute_q, mute_d;
  logic              busy_q;
  logic              done_q, done_d;
  entry_t            rd_entry;

  note_sequencer_pattern_ram u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (step_q),
    .rd_data (rd_entry)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    remain_d    = remain_q;
    count_to_d  = count_to_q;
    div_reset_d = 1'b0;
    mute_d      = mute_q;
    done_d      = 1'b0;

    // stop overrides everything outside IDLE, including the tick that would end a note
    if (state_q != ST_IDLE && bus.stop) begin
      state_d    = ST_IDLE;
      mute_d     = 1'b1;
      count_to_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            step_d  = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          if (rd_entry.dur == DUR_W'(END_MARK_DUR)) begin
            if (bus.loop_en && step_q != '0) begin
              step_d  = '0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_FINISH;
            end
          end else begin
            count_to_d  = rd_entry.div;
            remain_d    = rd_entry.dur;
            div_reset_d = 1'b1;
            mute_d      = (rd_entry.div == '0);
            state_d     = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (bus.tick) begin
            if (remain_q == DUR_W'(1)) begin
              if (step_q != ADDR_W'(DEPTH - 1)) begin
                step_d  = step_q + ADDR_W'(1);
                state_d = ST_FETCH;
              end else begin
                step_d  = '0;
                state_d = bus.loop_en ? ST_FETCH : ST_FINISH;
              end
            end else begin
              remain_d = remain_q - DUR_W'(1);
            end
          end
        end
        ST_FINISH: begin
          done_d     = 1'b1;
          mute_d     = 1'b1;
          count_to_d = '0;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      remain_q    <= '0;
      count_to_q  <= '0;
      div_reset_q <= 1'b0;
      mute_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      remain_q    <= remain_d;
      count_to_q  <= count_to_d;
      div_reset_q <= div_reset_d;
      mute_q      <= mute_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign bus.count_to  = count_to_q;
  assign bus.div_reset = div_reset_q;
  assign bus.mute      = mute_q;
  assign bus.busy      = busy_q;
  assign bus.step      = step_q;
  assign bus.done      = done_q;

endmodule
